// File: rtl/somador_serial.sv
// Bit-serial adder: one full-adder cell plus a carry flip-flop, LSB first.
// Produces the WIDTH-bit sum, the carry-out and a signed-overflow flag, with a done pulse.
module somador_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             vin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] saida,
  output logic             vai,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state, nstate;
  logic [WIDTH-1:0] ra, rb, res;
  logic            c, vn, ovn;
  logic [CW-1:0]   cnt;
  logic            s, cn, last;

  always_comb begin
    s    = ra[0] ^ rb[0] ^ c;
    cn   = (ra[0] & rb[0]) | (ra[0] & c) | (rb[0] & c);
    last = (cnt == CW'(WIDTH - 1));
  end

  always_comb begin
    nstate = state;
    busy   = 1'b0;
    case (state)
      IDLE:    if (start) nstate = SHIFT;
      SHIFT: begin
        busy = 1'b1;
        if (last) nstate = DONE;
      end
      DONE:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // done is registered alongside saida so the pulse and the result appear together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ra       <= '0;
      rb       <= '0;
      res      <= '0;
      c        <= 1'b0;
      vn       <= 1'b0;
      ovn      <= 1'b0;
      cnt      <= '0;
      done     <= 1'b0;
      saida    <= '0;
      vai      <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= nstate;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            ra  <= a;
            rb  <= b;
            c   <= vin;
            cnt <= '0;
            res <= '0;
          end
        end
        SHIFT: begin
          c   <= cn;
          ra  <= {1'b0, ra[WIDTH-1:1]};
          rb  <= {1'b0, rb[WIDTH-1:1]};
          res <= {s, res[WIDTH-1:1]};
          cnt <= cnt + 1'b1;
          if (last) begin
            vn  <= cn;
            ovn <= c ^ cn;
          end
        end
        DONE: begin
          saida    <= res;
          vai      <= vn;
          overflow <= ovn;
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
